// File: rtl/load_store_unit_if.sv
// Pipeline request/response channel and byte-wide data-memory port of load_store_unit.
// slave = the LSU side; master = pipeline plus memory side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        func3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic              err;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_write, func3, addr, wdata, mem_rdata,
        output req_ready, resp_valid, rdata, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, func3, addr, wdata, mem_rdata,
        input  req_ready, resp_valid, rdata, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-serial RV32I load/store initiator on an 8-bit synchronous memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word requests respond with err, no access.
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic              rd_valid_q;
    logic [1:0]        rd_idx_q;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              misalign;
    logic              req_legal;
    logic              unused_addr_hi;

    function automatic logic [1:0] last_idx(logic [2:0] f3);
        return (f3[1:0] == 2'b10) ? 2'd3 : {1'b0, f3[0]};
    endfunction

    function automatic logic [31:0] extend(logic [2:0] f3, logic [31:0] v);
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'h000000, v[7:0]};
            3'b101:  return {16'h0000, v[15:0]};
            default: return v;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((bus.func3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.func3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Stores only allow SB/SH/SW; loads reject 011, 110, 111.
    assign req_legal = !misalign && (bus.func3[1:0] != 2'b11) &&
                       (bus.req_write ? !bus.func3[2] : !(bus.func3[2] && bus.func3[1]));

    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

    // Read data returns one cycle after its strobe; drop it into its little-endian lane.
    always_comb begin
        asm_d = asm_q;
        if (rd_valid_q) begin
            asm_d[{rd_idx_q, 3'b000} +: 8] = bus.mem_rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        f3_d         = f3_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    f3_d    = bus.func3;
                    base_d  = bus.addr[ADDR_W-1:0];
                    wdata_d = bus.wdata;
                    idx_d   = 2'd0;
                    if (req_legal) begin
                        state_d     = XFER;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.req_write;
                        mem_addr_d  = bus.addr[ADDR_W-1:0];
                        mem_wdata_d = bus.req_write ? bus.wdata[7:0] : '0;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end
                end
            end
            XFER: begin
                if (idx_q == last_idx(f3_q)) begin
                    if (write_q) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    idx_d       = idx_q + 2'd1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = write_q;
                    mem_addr_d  = base_q + ADDR_W'(idx_d);
                    mem_wdata_d = write_q ? wdata_q[{idx_d, 3'b000} +: 8] : '0;
                end
            end
            DRAIN: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                rdata_d      = extend(f3_q, asm_d);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            f3_q         <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            idx_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            asm_q        <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            f3_q         <= f3_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            rd_valid_q   <= mem_en_q && !mem_we_q;
            rd_idx_q     <= idx_q;
            asm_q        <= asm_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.rdata      = rdata_q;
    assign bus.err        = err_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-serial load/store initiator in the MEM stage. It accepts one load or store request from the pipeline and performs it as a sequence of single-byte accesses on an 8-bit synchronous data-memory port. Stores are split into bytes; loads are reassembled and sign- or zero-extended per RV32I `func3`. The pipeline is held through `busy` until the single-cycle response.

## Interface
- `ADDR_W`, 8, memory byte-address width; `addr` bits above `ADDR_W` are ignored.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `func3`  in  3  RV32I load/store `func3`.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result.
- `err`  out  1  valid with `resp_valid`.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte, valid the cycle after a read strobe.

## Operation
- Request capture on accept: `req_write`, `func3`, `addr[ADDR_W-1:0]` and `wdata` are registered. Inputs are ignored at all other times.
- Access size from `func3`: 000/100 → 1 byte, 001/101 → 2 bytes, 010 → 4 bytes.
- Load extension: 000 sign-extends bit 7, 001 sign-extends bit 15, 100/101 zero-extend, 010 takes the full word.
- Illegal encodings:
  - Loads: 011, 110, 111.
  - Stores: any `func3[2]=1`, or 011.
  - Result: no memory access, `err=1`, `rdata` unchanged.
- FSM states: IDLE, XFER, DRAIN, RESP.
  - IDLE → XFER on accept of a legal request.
  - IDLE → RESP on accept of an illegal request.
  - XFER issues byte i = 0..N-1 (one per cycle) with `mem_addr = base + i` modulo 2^ADDR_W (wraps past the top address).
  - Bytes are little-endian: byte i is `wdata[8i+7:8i]` for stores and lands in `rdata[8i+7:8i]` for loads.
  - After byte N-1: store → RESP; load → DRAIN (captures the last `mem_rdata`), then RESP.
  - Load bytes are captured into a shift/assembly register on the edge after each read strobe.
  - RESP drives `resp_valid=1` for one cycle, then returns to IDLE.
- `rdata` is updated only on successful load responses and holds its value otherwise. Extension is applied at the DRAIN → RESP edge.
- `err=0` on successful responses.
- Outputs are registered; `mem_*` are driven only in XFER. Outside XFER: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.

## Timing
- Reset values:
  - State IDLE, `req_ready=1`, `busy=0`.
  - `resp_valid=0`, `rdata=0`, `err=0`.
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- Reset asserted mid-operation: outputs take their reset values immediately, with no further strobes. Bytes already written remain in memory.
- Latency, with the request accepted at edge k:
  - Strobes occur in cycles k+1 .. k+N.
  - Store: `resp_valid` in cycle k+N+1.
  - Load: `resp_valid` in cycle k+N+2.
  - Illegal request: `resp_valid` in cycle k+1.
- Throughput: the next request can be accepted on the edge ending the cycle after RESP, since `req_ready` is low during RESP.
- No response backpressure: `resp_valid` is never held.
- `req_valid` asserted while busy is simply not accepted; no request state changes.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]=1`, or a word with `addr[1:0]≠0`, is treated as an error.
  - Behaviour is identical to an illegal `func3`: IDLE → RESP, no strobes, `err=1`, `rdata` unchanged.
- Not defined: misaligned accesses proceed byte-serially like aligned ones; `err` is raised only for illegal `func3`.

## Test plan
The bench uses a behavioural 2^ADDR_W-byte synchronous memory.

- SW 0x000006F4 @0, then LB @0 → `rdata` 0xFFFFFFF4 (-12), `err=0`. Then LBU @0 → 244. Store response at k+5, load response at k+3.
- SW 0x0004E634 @4, then LH @4 → -6604 (0xFFFFE634). LHU @4 → 58932. LW @4 → 0x0004E634.
- SW 0x030106F4 @0, then LW @0 → 50398964. Check the byte strobe sequence: addresses 0,1,2,3 with data F4,06,01,03.
- SW 0xAABBCCDD @ 2^ADDR_W-2 → bytes land at FE, FF, 00, 01 (wrap). LW from the same address → 0xAABBCCDD, or `err=1` with no strobes when `LSU_MISALIGN_TRAP_EN` is defined.
- Illegal `func3=011` load → `resp_valid` at k+1, `err=1`, `mem_en` never high, `rdata` keeps its previous value.
- Assert `rst` low during the 2nd byte of an SW → all outputs reset immediately. Only byte 0 is modified in memory. The next request after reset completes normally.
